alu_issue: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_issue_if.sv | 52 +++++
 rtl/alu_watchdog.sv | 29 ++
 rtl/alu_issue.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, issue FSM states and
// the legal-opcode helper.
package alu_pkg;

    localparam int ALU_OP_W = 4;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'd1;
    localparam alu_op_t ALU_SUB = 4'd2;
    localparam alu_op_t ALU_MUL = 4'd3;
    localparam alu_op_t ALU_DIV = 4'd4;
    localparam alu_op_t ALU_AND = 4'd5;
    localparam alu_op_t ALU_OR  = 4'd6;
    localparam alu_op_t ALU_XOR = 4'd7;
    localparam alu_op_t ALU_NOT = 4'd8;
    localparam alu_op_t ALU_SHL = 4'd9;
    localparam alu_op_t ALU_SHR = 4'd10;

    localparam int FLAG_POSITIVE = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_CARRY    = 1;
    localparam int FLAG_ZERO     = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic is_legal_op(input alu_op_t op);
        return (op >= ALU_ADD) && (op <= ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-side and writeback signals of the issue stage.
// slave: the alu_issue block; master: CPU control, ALU and writeback consumer.
interface alu_issue_if #(
    parameter int N            = 16,
    parameter int ALU_OP_COUNT = 4,
    parameter int FLAGS_COUNT  = 4
);

    logic                    req_valid;
    logic                    req_ready;
    logic [ALU_OP_COUNT-1:0] req_opcode;
    logic [N-1:0]            req_a;
    logic [N-1:0]            req_b;
    logic [3:0]              req_dst;

    logic [N-1:0]            alu_a;
    logic [N-1:0]            alu_b;
    logic [ALU_OP_COUNT-1:0] alu_opcode;
    logic                    alu_start;
    logic [N-1:0]            alu_result;
    logic [N-1:0]            alu_high;
    logic [FLAGS_COUNT-1:0]  alu_flags;
    logic                    alu_finished;

    logic                    wb_valid;
    logic                    wb_ready;
    logic [3:0]              wb_dst;
    logic [N-1:0]            wb_result;
    logic [N-1:0]            wb_high;
    logic [FLAGS_COUNT-1:0]  wb_flags;
    logic                    wb_high_we;
    logic                    wb_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_dst,
        output req_ready,
        output alu_a, alu_b, alu_opcode, alu_start,
        input  alu_result, alu_high, alu_flags, alu_finished,
        output wb_valid, wb_dst, wb_result, wb_high, wb_flags, wb_high_we, wb_err,
        input  wb_ready
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_dst,
        input  req_ready,
        input  alu_a, alu_b, alu_opcode, alu_start,
        output alu_result, alu_high, alu_flags, alu_finished,
        input  wb_valid, wb_dst, wb_result, wb_high, wb_flags, wb_high_we, wb_err,
        output wb_ready
    );

endinterface

// File: rtl/alu_watchdog.sv
// Saturating WAIT-cycle counter; timeout is asserted while enabled and the
// count equals TIMEOUT.
module alu_watchdog #(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = enable && (count == W'(TIMEOUT));

endmodule

// File: rtl/alu_issue.sv
// ALU operation sequencer: request handshake, DIV start/finished protocol and
// registered writeback. Optional macro: ALU_DIV_ZERO_TRAP_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int N            = 16,
    parameter int ALU_OP_COUNT = 4,
    parameter int FLAGS_COUNT  = 4,
    parameter int TIMEOUT      = 63
) (
    input logic        CLK,
    input logic        RST_N,
    alu_issue_if.slave bus
);

    state_t state;
    state_t next_state;

    logic armed;
    logic accept;
    logic div_trap;
    logic ready;
    logic start;
    logic valid;
    logic wd_clear;
    logic wd_enable;
    logic wd_timeout;

    logic [N-1:0]            alu_a_q;
    logic [N-1:0]            alu_b_q;
    logic [ALU_OP_COUNT-1:0] alu_op_q;
    logic [3:0]              wb_dst_q;
    logic [N-1:0]            wb_result_q;
    logic [N-1:0]            wb_high_q;
    logic [FLAGS_COUNT-1:0]  wb_flags_q;
    logic                    wb_high_we_q;
    logic                    wb_err_q;

`ifdef ALU_DIV_ZERO_TRAP_EN
    assign div_trap = (bus.req_opcode == ALU_DIV) && (bus.req_b == '0);
`else
    assign div_trap = 1'b0;
`endif

    // armed keeps req_ready low in the reset cycle even though state is IDLE
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_legal_op(bus.req_opcode) || div_trap) begin
                        next_state = ST_DONE;
                    end else if (bus.req_opcode == ALU_DIV) begin
                        next_state = ST_START;
                    end else begin
                        next_state = ST_EXEC;
                    end
                end
            end
            ST_EXEC:  next_state = ST_DONE;
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.alu_finished || wd_timeout) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.wb_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        start     = 1'b0;
        valid     = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state)
            ST_IDLE:  ready = armed;
            ST_START: begin
                start    = 1'b1;
                wd_clear = 1'b1;
            end
            ST_WAIT:  wd_enable = 1'b1;
            ST_DONE:  valid = 1'b1;
            default:  ;
        endcase
    end

    assign accept = ready && bus.req_valid;

    // wb_* are cleared on acceptance so every completion path only sets what it owns
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            wb_dst_q     <= '0;
            wb_result_q  <= '0;
            wb_high_q    <= '0;
            wb_flags_q   <= '0;
            wb_high_we_q <= 1'b0;
            wb_err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_q      <= bus.req_a;
                        alu_b_q      <= bus.req_b;
                        wb_dst_q     <= bus.req_dst;
                        wb_result_q  <= '0;
                        wb_high_q    <= '0;
                        wb_flags_q   <= '0;
                        wb_high_we_q <= 1'b0;
                        wb_err_q     <= 1'b0;
                        if (!is_legal_op(bus.req_opcode)) begin
                            alu_op_q <= '0;
                            wb_err_q <= 1'b1;
                        end else begin
                            alu_op_q <= bus.req_opcode;
                            if (div_trap) begin
                                wb_result_q <= '1;
                                wb_high_q   <= bus.req_a;
                                wb_err_q    <= 1'b1;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    wb_result_q <= bus.alu_result;
                    wb_flags_q  <= bus.alu_flags;
                    if (alu_op_q == ALU_MUL) begin
                        wb_high_q    <= bus.alu_high;
                        wb_high_we_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.alu_finished) begin
                        wb_result_q  <= bus.alu_result;
                        wb_high_q    <= bus.alu_high;
                        wb_flags_q   <= bus.alu_flags;
                        wb_high_we_q <= 1'b1;
                    end else if (wd_timeout) begin
                        wb_err_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.wb_ready) begin
                        alu_op_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    alu_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clear  (wd_clear),
        .enable (wd_enable),
        .timeout(wd_timeout)
    );

    assign bus.req_ready  = ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_start  = start;
    assign bus.wb_valid   = valid;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.wb_result  = wb_result_q;
    assign bus.wb_high    = wb_high_q;
    assign bus.wb_flags   = wb_flags_q;
    assign bus.wb_high_we = wb_high_we_q;
    assign bus.wb_err     = wb_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: behavioural ALU stub, random and directed
// requests, writeback monitor with backpressure.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int N       = 16;
    localparam int OPW     = 4;
    localparam int FW      = 4;
    localparam int TIMEOUT = 63;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    alu_issue_if #(.N(N), .ALU_OP_COUNT(OPW), .FLAGS_COUNT(FW)) bus ();

    alu_issue #(
        .N(N), .ALU_OP_COUNT(OPW), .FLAGS_COUNT(FW), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] result;
        logic [15:0] high;
        logic [3:0]  flags;
        logic        high_we;
        logic        err;
        int          lat;
        int          starts;
        int          hold;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          div_lat = 1;
    bit          stub_hang = 1'b0;
    int          div_cnt = 0;
    int          starts = 0;
    int          hold = 0;
    bit          in_wb = 1'b0;
    logic [41:0] snap;
    exp_t        cur;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Plain arithmetic description of what the ALU computes for each opcode.
    function automatic void alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] r, output logic [15:0] h, output logic [3:0] f);
        logic [16:0] s;
        logic [31:0] p;
        logic        c;
        logic        v;
        r = '0; h = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            ALU_MUL: begin
                p = {16'h0, a} * {16'h0, b};
                r = p[15:0]; h = p[31:16];
            end
            ALU_DIV: begin
                if (b != 0) begin
                    r = a / b; h = a % b;
                end
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOT: r = ~a;
            ALU_SHL: r = a << b[3:0];
            ALU_SHR: r = a >> b[3:0];
            default: r = '0;
        endcase
        f = '0;
        f[FLAG_POSITIVE] = !r[15] && (r != 0);
        f[FLAG_OVERFLOW] = v;
        f[FLAG_CARRY]    = c;
        f[FLAG_ZERO]     = (r == 0);
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] dst, input int lat_div);
        exp_t        m;
        logic [15:0] r;
        logic [15:0] h;
        logic [3:0]  f;
        m.dst = dst; m.result = '0; m.high = '0; m.flags = '0;
        m.high_we = 1'b0; m.err = 1'b0; m.starts = 0; m.lat = 0; m.hold = 0; m.acc = 0;
        if (op == 4'd0 || op > 4'd10) begin
            m.err = 1'b1;
        end else if (op == ALU_DIV && b == 16'd0) begin
`ifdef ALU_DIV_ZERO_TRAP_EN
            m.result = 16'hFFFF;
            m.high   = a;
            m.err    = 1'b1;
`else
            // START, then the WAIT cycles until the count reads TIMEOUT
            m.err    = 1'b1;
            m.starts = 1;
            m.lat    = TIMEOUT + 2;
`endif
        end else begin
            alu_calc(op, a, b, r, h, f);
            m.result = r;
            m.flags  = f;
            if (op == ALU_MUL || op == ALU_DIV) begin
                m.high    = h;
                m.high_we = 1'b1;
            end
            m.starts = (op == ALU_DIV) ? 1 : 0;
            m.lat    = (op == ALU_DIV) ? lat_div + 1 : 1;
        end
        return m;
    endfunction

    // ALU stub: evaluates on the falling edge; DIV finishes div_lat cycles after start.
    always @(negedge CLK) begin
        logic [15:0] r;
        logic [15:0] h;
        logic [3:0]  f;
        logic        fin;
        alu_calc(bus.alu_opcode, bus.alu_a, bus.alu_b, r, h, f);
        fin = 1'b0;
        if (!RST_N) begin
            div_cnt = 0;
        end else if (bus.alu_start) begin
            div_cnt = (stub_hang || bus.alu_b == 16'd0) ? -1 : div_lat;
        end else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) fin = 1'b1;
        end
        bus.alu_finished = fin;
        if (bus.alu_opcode == ALU_DIV && !fin) begin
            bus.alu_result = 16'hDEAD;
            bus.alu_high   = 16'hBEEF;
            bus.alu_flags  = 4'hF;
        end else begin
            bus.alu_result = r;
            bus.alu_high   = (bus.alu_opcode == ALU_MUL || bus.alu_opcode == ALU_DIV) ? h : ~bus.alu_a;
            bus.alu_flags  = f;
        end
    end

    // Writeback monitor and consumer.
    always @(negedge CLK) begin
        if (!RST_N) begin
            in_wb = 1'b0;
            bus.wb_ready = 1'b0;
            starts = 0;
            hold = 0;
        end else begin
            if (bus.alu_start) starts++;
            if (bus.wb_valid) begin
                if (!in_wb) begin
                    in_wb = 1'b1;
                    snap = {bus.wb_dst, bus.wb_result, bus.wb_high, bus.wb_flags, bus.wb_high_we, bus.wb_err};
                    if (sb.size() == 0) begin
                        chk("unexpected_wb", 81'(bus.wb_valid), 81'(0));
                        hold = 0;
                    end else begin
                        cur = sb.pop_front();
                        chk("wb_dst", 81'(bus.wb_dst), 81'(cur.dst));
                        chk("wb_result", 81'(bus.wb_result), 81'(cur.result));
                        chk("wb_high", 81'(bus.wb_high), 81'(cur.high));
                        chk("wb_flags", 81'(bus.wb_flags), 81'(cur.flags));
                        chk("wb_high_we", 81'(bus.wb_high_we), 81'(cur.high_we));
                        chk("wb_err", 81'(bus.wb_err), 81'(cur.err));
                        chk("wb_latency", 81'(cyc - cur.acc), 81'(cur.lat));
                        chk("alu_start_cycles", 81'(starts), 81'(cur.starts));
                        chk("req_ready_in_done", 81'(bus.req_ready), 81'(0));
                        hold = cur.hold;
                    end
                    starts = 0;
                end else begin
                    chk("wb_hold_stable",
                        81'({bus.wb_dst, bus.wb_result, bus.wb_high, bus.wb_flags, bus.wb_high_we, bus.wb_err, bus.req_ready}),
                        81'({snap, 1'b0}));
                end
                if (hold > 0) begin
                    hold--;
                    bus.wb_ready = 1'b0;
                end else begin
                    bus.wb_ready = 1'b1;
                end
            end else begin
                if (in_wb) chk("alu_opcode_idle", 81'(bus.alu_opcode), 81'(0));
                in_wb = 1'b0;
                bus.wb_ready = ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] dst, input int hold_n);
        exp_t e;
        int   w;
        w = 0;
        @(negedge CLK);
        while (!bus.req_ready && w < 500) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 500) begin
            chk("req_ready_wait", 81'(bus.req_ready), 81'(1));
            return;
        end
        div_lat = $urandom_range(1, 6);
        e = model(op, a, b, dst, div_lat);
        e.hold = hold_n;
        e.acc  = cyc + 1;
        sb.push_back(e);
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_dst    = dst;
        bus.req_valid  = 1'b1;
        @(negedge CLK);
        bus.req_valid  = 1'b0;
        bus.req_opcode = 4'($urandom);
        bus.req_a      = 16'($urandom);
        bus.req_b      = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || bus.wb_valid) && w < 2000) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 2000) chk("drain_wait", 81'(sb.size()), 81'(0));
    endtask

    function automatic logic [80:0] all_outputs();
        return {bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_start, bus.wb_valid,
                bus.wb_dst, bus.wb_result, bus.wb_high, bus.wb_flags, bus.wb_high_we, bus.wb_err};
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        RST_N          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_dst    = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", all_outputs(), '0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", 81'(bus.req_ready), 81'(1));

        issue(ALU_ADD, 16'h7FFF, 16'h0001, 4'd1, 0);
        issue(ALU_MUL, 16'h1234, 16'h0100, 4'd2, 0);
        issue(ALU_DIV, 16'd100, 16'd7, 4'd3, 0);
        issue(ALU_DIV, 16'h00A5, 16'd0, 4'd4, 0);
        issue(ALU_SUB, 16'd9, 16'd9, 4'd5, 5);
        issue(4'hF, 16'h1111, 16'h2222, 4'd6, 0);
        issue(4'h0, 16'h3333, 16'h4444, 4'd7, 2);
        drain();

        // Reset while the divider is busy: no writeback may follow.
        stub_hang = 1'b1;
        @(negedge CLK);
        bus.req_opcode = ALU_DIV;
        bus.req_a      = 16'd200;
        bus.req_b      = 16'd3;
        bus.req_dst    = 4'd8;
        bus.req_valid  = 1'b1;
        @(negedge CLK);
        bus.req_valid  = 1'b0;
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("reset_in_wait_outputs", all_outputs(), '0);
        RST_N = 1'b1;
        stub_hang = 1'b0;
        @(negedge CLK);
        chk("ready_after_wait_reset", 81'(bus.req_ready), 81'(1));
        issue(ALU_ADD, 16'd2, 16'd3, 4'd9, 0);
        drain();

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
            if (op == ALU_DIV && $urandom_range(0, 9) == 0) b = 16'd0;
            issue(op, a, b, 4'($urandom), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
